// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic player that captures the game's LED sequence and replays it on botoes,
// optionally appending one new value per round in modo2.
module jogador_automatico #(
  parameter int DEPTH  = 16,
  parameter int PULSO  = 3,
  parameter int ESPACO = 2503
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       modo2,
  input  logic       forca_erro,
  input  logic [3:0] leds,
  input  logic       vez_jogador,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       pronto,
  output logic [3:0] botoes,
  output logic       ativo,
  output logic       fim,
  output logic       erro_capacidade,
  output logic [3:0] db_estado,
  output logic [4:0] db_comprimento
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {OCIOSO, OBSERVA, APERTA, SOLTA, GRAVA_APERTA, GRAVA_SOLTA, FIM} estado_t;
  estado_t state_q, state_d;
  logic [CW-1:0] cap_q, cap_d, play_q, play_d, comp_q, comp_d;
  logic [11:0] timer_q, timer_d;
  logic [1:0] novo_q, novo_d;
  logic erro_q, erro_d, vez_prev_q;
  logic [3:0] leds_prev_q, wdata, atual;
  logic [AW-1:0] waddr;
  logic we, captura, sobe;
  logic [3:0] mem_q [DEPTH];
  always_comb begin
    state_d = state_q;
    cap_d = cap_q;
    play_d = play_q;
    comp_d = comp_q;
    novo_d = novo_q;
    erro_d = erro_q;
    we = 1'b0;
    waddr = cap_q[AW-1:0];
    wdata = leds;
    captura = leds != 4'b0 && leds_prev_q == 4'b0;
    sobe = vez_jogador && !vez_prev_q;
    if (!habilitar) state_d = OCIOSO;
    else if (state_q != OCIOSO && (ganhou || perdeu || pronto)) state_d = FIM;
    else
      case (state_q)
        OCIOSO: if (!pronto) begin
          state_d = OBSERVA;
          cap_d = '0;
          comp_d = '0;
        end
        OBSERVA: begin
          if (captura) begin
            if (cap_q == CW'(DEPTH)) erro_d = 1'b1;
            else begin
              we = 1'b1;
              cap_d = cap_q + CW'(1);
              comp_d = cap_q + CW'(1);
            end
          end
          // a capture on the same cycle as the turn edge still counts toward the replay
          if (sobe) begin
            if (comp_d != '0) begin
              state_d = APERTA;
              play_d = '0;
            end else if (modo2) state_d = GRAVA_APERTA;
          end
        end
        APERTA: if (timer_q == 12'(PULSO - 1)) state_d = SOLTA;
        SOLTA: if (timer_q == 12'(ESPACO)) begin
          play_d = play_q + CW'(1);
          if (play_q + CW'(1) < comp_q) state_d = APERTA;
          else begin
            state_d = modo2 ? GRAVA_APERTA : OBSERVA;
            cap_d = '0;
          end
        end
        GRAVA_APERTA: if (timer_q == 12'(PULSO - 1)) begin
          state_d = GRAVA_SOLTA;
          novo_d = novo_q + 2'd1;
          if (comp_q == CW'(DEPTH)) erro_d = 1'b1;
          else begin
            we = 1'b1;
            waddr = comp_q[AW-1:0];
            wdata = 4'b1 << novo_q;
            comp_d = comp_q + CW'(1);
          end
        end
        GRAVA_SOLTA: if (timer_q == 12'(ESPACO)) begin
          state_d = OBSERVA;
          cap_d = '0;
        end
        default: ;
      endcase
    timer_d = state_d == state_q ? timer_q + 12'd1 : 12'd0;
  end
  always_ff @(posedge clock) begin
    leds_prev_q <= leds;
    vez_prev_q <= vez_jogador;
    if (we) mem_q[waddr] <= wdata;
    if (!reset) begin
      state_q <= OCIOSO;
      cap_q <= '0;
      play_q <= '0;
      comp_q <= '0;
      timer_q <= '0;
      novo_q <= '0;
      erro_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      play_q <= play_d;
      comp_q <= comp_d;
      timer_q <= timer_d;
      novo_q <= novo_d;
      erro_q <= erro_d;
    end
  end
  always_comb begin
    atual = mem_q[play_q[AW-1:0]];
    botoes = state_q == APERTA ? (forca_erro ? {atual[2:0], atual[3]} : atual) :
             state_q == GRAVA_APERTA ? 4'b1 << novo_q : 4'b0;
  end
  assign ativo = state_q != OCIOSO && state_q != FIM;
  assign fim = state_q == FIM;
  assign erro_capacidade = erro_q;
  assign db_estado = {1'b0, state_q};
  assign db_comprimento = 5'(comp_q);
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: directed bench for the automatic player, expected values computed by hand.
module tb_jogador_automatico;
  localparam int GAP = 2504;
  logic clock = 1'b0, reset, habilitar, modo2, forca_erro, vez_jogador, ganhou, perdeu, pronto;
  logic [3:0] leds, botoes, db_estado;
  logic ativo, fim, erro_capacidade;
  logic [4:0] db_comprimento;
  int n_cmp = 0, n_err = 0;
  jogador_automatico dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .modo2(modo2), .forca_erro(forca_erro),
    .leds(leds), .vez_jogador(vez_jogador), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .botoes(botoes), .ativo(ativo), .fim(fim), .erro_capacidade(erro_capacidade),
    .db_estado(db_estado), .db_comprimento(db_comprimento)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic press(input string tag, input logic [3:0] v, input int gap);
    int n;
    chk({tag, "_val"}, botoes, v);
    n = 0;
    while (botoes == v && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_len"}, n, 3);
    if (gap >= 0) begin
      n = 0;
      while (botoes == 4'b0 && n < 3000) begin
        tick();
        n++;
      end
      chk({tag, "_gap"}, n, gap);
    end
  endtask
  task automatic pulse_leds(input logic [3:0] v);
    leds = v;
    tick();
    leds = 4'b0;
    tick();
  endtask
  initial begin
    reset = 1'b0; habilitar = 1'b0; modo2 = 1'b0; forca_erro = 1'b0; vez_jogador = 1'b0;
    ganhou = 1'b0; perdeu = 1'b0; pronto = 1'b0; leds = 4'b0;
    tick(); tick();
    chk("rst_estado", db_estado, 0);
    chk("rst_botoes", botoes, 0);
    chk("rst_ativo", ativo, 0);
    chk("rst_fim", fim, 0);
    chk("rst_erro", erro_capacidade, 0);
    chk("rst_comp", db_comprimento, 0);
    reset = 1'b1;
    habilitar = 1'b1;
    tick();
    chk("obs_estado", db_estado, 1);
    chk("obs_ativo", ativo, 1);
    pulse_leds(4'b0001);
    pulse_leds(4'b0100);
    chk("t2_comp", db_comprimento, 2);
    vez_jogador = 1'b1;
    tick();
    press("t2p0", 4'b0001, GAP);
    press("t2p1", 4'b0100, -1);
    repeat (GAP) tick();
    chk("t2_volta", db_estado, 1);
    chk("t2_comp_fim", db_comprimento, 2);
    vez_jogador = 1'b0;
    tick();
    leds = 4'b0100;
    vez_jogador = 1'b1;
    tick();
    leds = 4'b0;
    chk("t6_comp", db_comprimento, 1);
    press("t6p0", 4'b0100, -1);
    repeat (GAP) tick();
    chk("t6_volta", db_estado, 1);
    vez_jogador = 1'b0;
    tick();
    pulse_leds(4'b1000);
    vez_jogador = 1'b1;
    forca_erro = 1'b1;
    tick();
    chk("t4_rot", botoes, 4'b0001);
    perdeu = 1'b1;
    tick();
    perdeu = 1'b0;
    chk("t4_estado", db_estado, 6);
    chk("t4_fim", fim, 1);
    chk("t4_botoes", botoes, 0);
    chk("t4_ativo", ativo, 0);
    tick();
    chk("t4_fica", db_estado, 6);
    habilitar = 1'b0;
    tick();
    chk("t4_ocioso", db_estado, 0);
    forca_erro = 1'b0;
    vez_jogador = 1'b0;
    habilitar = 1'b1;
    tick();
    pulse_leds(4'b0010);
    vez_jogador = 1'b1;
    tick();
    chk("t1_aperta", botoes, 4'b0010);
    reset = 1'b0;
    tick();
    chk("t1_botoes", botoes, 0);
    chk("t1_estado", db_estado, 0);
    chk("t1_comp", db_comprimento, 0);
    tick();
    reset = 1'b1;
    vez_jogador = 1'b0;
    modo2 = 1'b1;
    tick();
    chk("t3_obs", db_estado, 1);
    pulse_leds(4'b0010);
    vez_jogador = 1'b1;
    tick();
    press("t3r1p0", 4'b0010, GAP);
    press("t3r1g", 4'b0001, -1);
    chk("t3r1_comp", db_comprimento, 2);
    repeat (GAP) tick();
    chk("t3r1_volta", db_estado, 1);
    vez_jogador = 1'b0;
    tick();
    vez_jogador = 1'b1;
    tick();
    press("t3r2p0", 4'b0010, GAP);
    press("t3r2p1", 4'b0001, GAP);
    press("t3r2g", 4'b0010, -1);
    chk("t3r2_comp", db_comprimento, 3);
    repeat (GAP) tick();
    chk("t3r2_volta", db_estado, 1);
    vez_jogador = 1'b0;
    modo2 = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) pulse_leds(4'(1 << (i % 4)));
    chk("t5_comp16", db_comprimento, 16);
    chk("t5_erro0", erro_capacidade, 0);
    pulse_leds(4'b0001);
    chk("t5_comp17", db_comprimento, 16);
    chk("t5_erro1", erro_capacidade, 1);
    habilitar = 1'b0;
    tick();
    chk("t6_ocioso", db_estado, 0);
    chk("t5_sticky", erro_capacidade, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
